kfmmc_spi_target: RTL
=====================

KFMMC_SPI_TARGET -- requirements
Module: KFMMC_SPI_TARGET

Interface
REQ-001 SHALL have parameter SYNC_STAGES, default 2, meaning the number of flip-flop stages synchronizing spi_cs_n, spi_clk and spi_mosi into the clock domain (minimum 2).
REQ-002 SHALL have port clock  input  1  system clock; all logic is on its rising edge.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port spi_cs_n  input  1  chip select from the SPI initiator, active low.
REQ-005 SHALL have port spi_clk  input  1  SPI clock from the initiator (mode 0, idle low).
REQ-006 SHALL have port spi_mosi  input  1  serial data from the initiator, MSB first.
REQ-007 SHALL have port spi_miso  output  1  serial data to the initiator, MSB first.
REQ-008 SHALL have port spi_miso_oe  output  1  MISO output enable; 1 while the target is selected.
REQ-009 SHALL have port recv_data  output  8  last complete byte received.
REQ-010 SHALL have port recv_valid  output  1  one-cycle pulse marking that recv_data was updated.
REQ-011 SHALL have port send_data  input  8  next byte to transmit.
REQ-012 SHALL have port send_load  input  1  writes send_data into the transmit holding register.
REQ-013 SHALL have port send_ready  output  1  1 when the holding register is empty.
REQ-014 SHALL have port underrun  output  1  sticky flag: a byte started while the holding register was empty.
REQ-015 SHALL have port clear_flags  input  1  clears underrun.
REQ-016 SHALL have port busy_flag  output  1  1 while selected (synchronized spi_cs_n low).

Function
REQ-017 SHALL pass cs, clk and mosi through SYNC_STAGES synchronizer stages, then one registered stage for edge detection; events act 3 clocks after the pin change (SYNC_STAGES=2).
REQ-018 SHALL have two states: IDLE (synchronized cs_n high) and SELECTED (synchronized cs_n low).
REQ-019 SHALL, in IDLE, hold bit_count=0, spi_miso=1, spi_miso_oe=0, and ignore spi_clk edges.
REQ-020 SHALL, on the IDLE->SELECTED transition, load the tx shift register from the holding register, or with 8'hFF if the holding register is empty, and enter SELECTED.
REQ-021 SHALL drive spi_miso from tx_shift[7] and set spi_miso_oe=1 in SELECTED.
REQ-022 SHALL, on each synchronized spi_clk rising edge in SELECTED, shift the mosi sample into the rx shift register LSB and increment the 3-bit bit_count.
REQ-023 SHALL, on the rising edge where bit_count wraps 7->0, update recv_data with the full byte (MSB = first bit) and pulse recv_valid in the same cycle; it SHALL also set byte_done.
REQ-024 SHALL, on a synchronized spi_clk falling edge with byte_done=0, shift tx_shift left with a 1 filled in.
REQ-025 SHALL, on a synchronized spi_clk falling edge with byte_done=1, clear byte_done and reload tx_shift from the holding register, or with 8'hFF if it is empty.
REQ-026 SHALL, on each load of tx_shift (REQ-020 or REQ-025), mark the holding register empty (send_ready=1) if it was full, and set underrun=1 if it was empty.
REQ-027 SHALL, on send_load with send_ready=1, capture send_data and clear send_ready on the next cycle.
REQ-028 SHALL ignore send_load while send_ready=0; the holding register is unchanged.
REQ-029 SHALL, when send_load coincides with a tx_shift load that consumes a full holding register, load the old holding value into tx_shift, store the new send_data in the holding register, and keep send_ready=0.
REQ-030 SHALL, when send_load coincides with a load from an empty holding register, send 8'hFF, set underrun, and capture send_data with send_ready=0.
REQ-031 SHALL clear underrun on clear_flags; a simultaneous set SHALL win.
REQ-032 SHALL, when cs_n deasserts mid-byte (bit_count!=0), discard the partial byte with no recv_valid, clear bit_count and byte_done, and return to IDLE.
REQ-033 SHALL preserve the holding register across a mid-byte deassert.
REQ-034 SHALL require an spi_clk high or low phase of at least SYNC_STAGES+2 clocks; shorter phases are unsupported.

Reset
REQ-035 SHALL, on reset, force state=IDLE, bit_count=0, byte_done=0, rx/tx shift registers=8'h00/8'hFF, recv_data=8'h00, recv_valid=0, send_ready=1, underrun=0, spi_miso=1, spi_miso_oe=0 and busy_flag=0.
REQ-036 SHALL allow reset asserted while SELECTED to abort the transfer without asserting recv_valid, regardless of pin state.

Verification
REQ-037 SHALL cover this scenario: preload 8'hA5, then the initiator sends 8'h3C with a 10-clock half-period -> MISO bits 1,0,1,0,0,1,0,1; one recv_valid with recv_data=8'h3C; send_ready=1 after cs falls.
REQ-038 SHALL cover this scenario: no preload, one byte transferred -> MISO all ones (8'hFF); underrun=1 until clear_flags, then 0.
REQ-039 SHALL cover this scenario: back-to-back 8'h01, 8'h02 with 8'h55 then 8'hAA loaded on send_ready -> MISO 8'h55 then 8'hAA; recv_valid pulses twice with 8'h01, 8'h02.
REQ-040 SHALL cover this scenario: cs_n raised after 5 rising edges -> no recv_valid, spi_miso_oe=0; the next full byte 8'hC3 is received correctly.
REQ-041 SHALL cover this scenario: send_load pulsed on the exact cycle of the REQ-025 reload with holding=8'h11, new=8'h22 -> 8'h11 transmitted, holding=8'h22, send_ready=0.
REQ-042 SHALL cover this scenario: reset pulsed mid-byte -> all outputs match REQ-035 on the next cycle.

Source files
------------

// File: rtl/kfmmc_spi_target.sv
// kfmmc_spi_target: SPI mode-0 target with a one-byte transmit holding register.
// The SPI pins are synchronized into the system clock domain. The design
// oversamples the SPI clock and reacts to its edges one cycle after they leave
// the synchronizer.
module kfmmc_spi_target #(
  parameter int SYNC_STAGES = 2
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       spi_cs_n,
  input  logic       spi_clk,
  input  logic       spi_mosi,
  output logic       spi_miso,
  output logic       spi_miso_oe,
  output logic [7:0] recv_data,
  output logic       recv_valid,
  input  logic [7:0] send_data,
  input  logic       send_load,
  output logic       send_ready,
  output logic       underrun,
  input  logic       clear_flags,
  output logic       busy_flag
);

  typedef enum logic {
    ST_IDLE     = 1'b0,
    ST_SELECTED = 1'b1
  } state_t;

  logic [SYNC_STAGES-1:0] cs_sync_q, cs_sync_d;
  logic [SYNC_STAGES-1:0] clk_sync_q, clk_sync_d;
  logic [SYNC_STAGES-1:0] mosi_sync_q, mosi_sync_d;
  logic                   clk_prev_q, clk_prev_d;

  state_t     state_q, state_d;
  logic [2:0] bit_count_q, bit_count_d;
  logic       byte_done_q, byte_done_d;
  logic [7:0] rx_shift_q, rx_shift_d;
  logic [7:0] tx_shift_q, tx_shift_d;
  logic [7:0] recv_data_q, recv_data_d;
  logic       recv_valid_q, recv_valid_d;
  logic [7:0] hold_q, hold_d;
  logic       send_ready_q, send_ready_d;
  logic       underrun_q, underrun_d;
  logic       miso_q, miso_d;
  logic       miso_oe_q, miso_oe_d;
  logic       busy_q, busy_d;

  logic cs_sel_s;
  logic clk_s;
  logic mosi_s;
  logic clk_rise_s;
  logic clk_fall_s;
  logic tx_load_s;
  logic accept_s;

  // Shift the raw pins through the synchronizer chains and remember the last SPI clock level.
  always_comb begin
    cs_sync_d   = {cs_sync_q[SYNC_STAGES-2:0], spi_cs_n};
    clk_sync_d  = {clk_sync_q[SYNC_STAGES-2:0], spi_clk};
    mosi_sync_d = {mosi_sync_q[SYNC_STAGES-2:0], spi_mosi};
    clk_prev_d  = clk_sync_q[SYNC_STAGES-1];
  end

  // Decode the synchronized pins into select level and SPI clock edges.
  always_comb begin
    cs_sel_s   = ~cs_sync_q[SYNC_STAGES-1];
    clk_s      = clk_sync_q[SYNC_STAGES-1];
    mosi_s     = mosi_sync_q[SYNC_STAGES-1];
    clk_rise_s = clk_s & ~clk_prev_q;
    clk_fall_s = ~clk_s & clk_prev_q;
  end

  // Compute the next state, the shift registers, the holding register and the flags.
  always_comb begin
    state_d      = state_q;
    bit_count_d  = bit_count_q;
    byte_done_d  = byte_done_q;
    rx_shift_d   = rx_shift_q;
    tx_shift_d   = tx_shift_q;
    recv_data_d  = recv_data_q;
    recv_valid_d = 1'b0;
    hold_d       = hold_q;
    send_ready_d = send_ready_q;
    underrun_d   = underrun_q;
    tx_load_s    = 1'b0;
    accept_s     = 1'b0;

    case (state_q)
      ST_IDLE: begin
        bit_count_d = 3'd0;
        byte_done_d = 1'b0;
        if (cs_sel_s) begin
          state_d   = ST_SELECTED;
          tx_load_s = 1'b1;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_SELECTED: begin
        if (!cs_sel_s) begin
          // Deselect drops any partial byte; the holding register is untouched.
          state_d     = ST_IDLE;
          bit_count_d = 3'd0;
          byte_done_d = 1'b0;
        end else if (clk_rise_s) begin
          rx_shift_d  = {rx_shift_q[6:0], mosi_s};
          bit_count_d = bit_count_q + 3'd1;
          if (bit_count_q == 3'd7) begin
            recv_data_d  = {rx_shift_q[6:0], mosi_s};
            recv_valid_d = 1'b1;
            byte_done_d  = 1'b1;
          end else begin
            byte_done_d = byte_done_q;
          end
        end else if (clk_fall_s) begin
          if (byte_done_q) begin
            byte_done_d = 1'b0;
            tx_load_s   = 1'b1;
          end else begin
            tx_shift_d = {tx_shift_q[6:0], 1'b1};
          end
        end else begin
          state_d = ST_SELECTED;
        end
      end
      default: begin
        state_d     = ST_IDLE;
        bit_count_d = 3'd0;
        byte_done_d = 1'b0;
      end
    endcase

    // A load consumes the holding byte, or sends all ones and flags an underrun.
    if (tx_load_s) begin
      tx_shift_d = send_ready_q ? 8'hFF : hold_q;
    end else begin
      tx_shift_d = tx_shift_d;
    end

    // New data is taken when the holding register is empty or is being emptied now.
    accept_s = send_load & (send_ready_q | tx_load_s);
    if (accept_s) begin
      hold_d       = send_data;
      send_ready_d = 1'b0;
    end else if (tx_load_s) begin
      send_ready_d = 1'b1;
    end else begin
      send_ready_d = send_ready_q;
    end

    // Setting underrun takes priority over clearing it.
    if (tx_load_s && send_ready_q) begin
      underrun_d = 1'b1;
    end else if (clear_flags) begin
      underrun_d = 1'b0;
    end else begin
      underrun_d = underrun_q;
    end
  end

  // Registered pin outputs follow the next state so they change together with it.
  always_comb begin
    miso_d    = 1'b1;
    miso_oe_d = 1'b0;
    busy_d    = 1'b0;
    if (state_d == ST_SELECTED) begin
      miso_d    = tx_shift_d[7];
      miso_oe_d = 1'b1;
      busy_d    = 1'b1;
    end else begin
      miso_d    = 1'b1;
      miso_oe_d = 1'b0;
      busy_d    = 1'b0;
    end
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      cs_sync_q    <= {SYNC_STAGES{1'b1}};
      clk_sync_q   <= {SYNC_STAGES{1'b0}};
      mosi_sync_q  <= {SYNC_STAGES{1'b0}};
      clk_prev_q   <= 1'b0;
      state_q      <= ST_IDLE;
      bit_count_q  <= 3'd0;
      byte_done_q  <= 1'b0;
      rx_shift_q   <= 8'h00;
      tx_shift_q   <= 8'hFF;
      recv_data_q  <= 8'h00;
      recv_valid_q <= 1'b0;
      hold_q       <= 8'h00;
      send_ready_q <= 1'b1;
      underrun_q   <= 1'b0;
      miso_q       <= 1'b1;
      miso_oe_q    <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      cs_sync_q    <= cs_sync_d;
      clk_sync_q   <= clk_sync_d;
      mosi_sync_q  <= mosi_sync_d;
      clk_prev_q   <= clk_prev_d;
      state_q      <= state_d;
      bit_count_q  <= bit_count_d;
      byte_done_q  <= byte_done_d;
      rx_shift_q   <= rx_shift_d;
      tx_shift_q   <= tx_shift_d;
      recv_data_q  <= recv_data_d;
      recv_valid_q <= recv_valid_d;
      hold_q       <= hold_d;
      send_ready_q <= send_ready_d;
      underrun_q   <= underrun_d;
      miso_q       <= miso_d;
      miso_oe_q    <= miso_oe_d;
      busy_q       <= busy_d;
    end
  end

  assign spi_miso    = miso_q;
  assign spi_miso_oe = miso_oe_q;
  assign recv_data   = recv_data_q;
  assign recv_valid  = recv_valid_q;
  assign send_ready  = send_ready_q;
  assign underrun    = underrun_q;
  assign busy_flag   = busy_q;

endmodule
